// File: rtl/imem_responder_pkg.sv
// Shared bus definitions for the instruction-fetch side: responder state encoding
// and HRESP values.
package imem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    DATA = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } imem_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: combinational read, synchronous write, never cleared.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/imem_responder.sv
// AHB-style instruction memory responder with optional wait states and a
// two-cycle error response for misaligned or out-of-range addresses.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] HADDR,
  input  logic        HTRANS,
  input  logic        HWRITE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) << 2;

  imem_state_e           state, state_next;
  logic [WAIT_CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [63:0]           offset;
  logic                  addr_err;
  logic                  accept;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic                  unused_bits;

  assign offset      = HADDR - BASE_ADDR;
  assign addr_err    = (HADDR[1:0] != 2'b00) || (offset >= LIMIT);
  assign HREADY      = (state == IDLE) || (state == DATA) || (state == ERR2);
  assign accept      = HTRANS && HREADY;
  assign mem_we      = (state == DATA) && write_q;
  assign unused_bits = ^HWDATA[63:32];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        idx_q   <= offset[IDX_W+1:2];
        write_q <= HWRITE;
      end
    end
  end

  // Every HREADY=1 state may accept a new address phase, giving zero-gap pipelining.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      WAIT: begin
        if (cnt == WAIT_CNT_W'(1)) begin
          state_next = DATA;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - WAIT_CNT_W'(1);
        end
      end
      ERR1: state_next = ERR2;
      default: begin
        if (!accept) begin
          state_next = IDLE;
        end else if (addr_err) begin
          state_next = ERR1;
        end else if (WAIT_STATES == 0) begin
          state_next = DATA;
        end else begin
          state_next = WAIT;
          cnt_next   = WAIT_CNT_W'(WAIT_STATES);
        end
      end
    endcase
  end

  always_comb begin
    HRDATA = 64'h0;
    HRESP  = HRESP_OKAY;
    if (state == DATA && !write_q) HRDATA = {32'h0, mem_rdata};
    if (state == ERR1 || state == ERR2) HRESP = HRESP_ERROR;
  end

  // A write lands at the edge ending DATA, so a following read sees it directly.
  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .CLK  (CLK),
    .we   (mem_we),
    .idx  (idx_q),
    .wdata(HWDATA[31:0]),
    .rdata(mem_rdata)
  );

endmodule
